// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32IM MUL/MULH/MULHSU/MULHU.
// One partial product per clock; sign fix-up applied once at the end.
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [2*XLEN-1:0] addend, fixed;

  always_comb begin
    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed
    sgn1   = ((op == 2'b01) || (op == 2'b10)) && rs1[XLEN-1];
    sgn2   = (op == 2'b01) && rs2[XLEN-1];
    abs1   = sgn1 ? -rs1 : rs1;
    abs2   = sgn2 ? -rs2 : rs2;
    addend = {{XLEN{1'b0}}, mcand_q} << count_q;
    fixed  = neg_q ? -prod_q : prod_q;

    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    count_d  = count_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          mcand_d  = abs1;
          mplier_d = abs2;
          neg_d    = sgn1 ^ sgn2;
          prod_d   = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (mplier_q[count_q]) begin
          prod_d = prod_q + addend;
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        prod_d   = fixed;
        result_d = (op_q == 2'b00) ? fixed[XLEN-1:0]
                                   : fixed[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: M-extension products, latency,
// ignored starts while busy/done, and asynchronous reset abort.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_err;
  int c;
  int pulses;

  mul_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // c counts cycles from the one in which start is presented (c=0)
  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(posedge clk);
    #1;
    op = o; rs1 = a; rs2 = b; start = 1'b1; c = 0;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && c < 60) step();
    chk({tag, "_lat"}, 32'(c), 32'd34);
    chk(tag, result, exp);
    step();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    n_chk = 0; n_err = 0; c = 0; pulses = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A);
    do_op("mul_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    do_op("mulh_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
    do_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    do_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulhu_zero", 2'b11, 32'd0, 32'h12345678, 32'd0);

    // starts during CALC and DONE are ignored; the IDLE one is taken
    @(posedge clk);
    #1;
    op = 2'b00; rs1 = 32'd7; rs2 = 32'd6; start = 1'b1; c = 0;
    step();
    start = 1'b0;
    while (!done && c < 60) begin
      if (c == 5) begin
        op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("ign_lat", 32'(c), 32'd34);
    chk("ign_result", result, 32'h0000002A);
    op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
    step();
    chk("ign_done_busy", 32'(busy), 32'd0);
    chk("ign_done_result", result, 32'h0000002A);
    step();
    start = 1'b0;
    chk("acc_idle_busy", 32'(busy), 32'd1);
    while (!done && c < 100) step();
    chk("acc_lat", 32'(c), 32'd69);
    chk("acc_result", result, 32'hFFFFFFFE);

    // asynchronous reset in the middle of an operation
    @(posedge clk);
    #1;
    op = 2'b00; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; c = 0;
    step();
    start = 1'b0;
    while (c < 10) step();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    #12;
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_idle_result", result, 32'd0);

    do_op("post_rst_mul", 2'b00, 32'd9, 32'd9, 32'h00000051);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
